// File: rtl/hci_package.sv
// Shared HCI interconnect definitions: default bus widths and the per-bank
// test-and-set adapter state encoding.
package hci_package;

  localparam int unsigned DEFAULT_AW = 10;
  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_BW = 8;

  typedef enum logic {
    HCI_TS_IDLE = 1'b0,
    HCI_TS_WR   = 1'b1
  } hci_ts_state_e;

endpackage

// File: rtl/hci_mem_ts_adapter.sv
// Per-bank test-and-set adapter between an HCI memory-side master port and a
// single-port TCDM SRAM bank. Plain reads/writes pass straight through; a read
// flagged with in_ts_set_i is followed by a locked all-ones write to the same
// word. Optional macro HCI_TS_ADAPTER_CNT_EN adds ts_count_o, the number of
// completed test-and-set writes.
module hci_mem_ts_adapter
  import hci_package::*;
#(
  parameter int unsigned AW = DEFAULT_AW,
  parameter int unsigned DW = DEFAULT_DW,
  parameter int unsigned BW = DEFAULT_BW,
  parameter int unsigned IW = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
`ifdef HCI_TS_ADAPTER_CNT_EN
  output logic [31:0]        ts_count_o,
`endif
  input  logic               in_req_i,
  input  logic [AW-1:0]      in_add_i,
  input  logic               in_wen_i,
  input  logic [DW-1:0]      in_data_i,
  input  logic [DW/BW-1:0]   in_be_i,
  input  logic [IW-1:0]      in_id_i,
  input  logic               in_ts_set_i,
  output logic               in_gnt_o,
  output logic               in_r_valid_o,
  output logic [DW-1:0]      in_r_data_o,
  output logic [IW-1:0]      in_r_id_o,
  output logic               bank_req_o,
  output logic [AW-1:0]      bank_add_o,
  output logic               bank_wen_o,
  output logic [DW-1:0]      bank_data_o,
  output logic [DW/BW-1:0]   bank_be_o,
  input  logic               bank_gnt_i,
  input  logic [DW-1:0]      bank_r_data_i
);

  localparam int unsigned BEW = DW / BW;
  localparam logic [DW-1:0]  TS_WDATA = '1;
  localparam logic [BEW-1:0] TS_WBE   = '1;

  hci_ts_state_e r_state;
  hci_ts_state_e w_state_next;
  logic [AW-1:0] r_ts_add;
  logic          r_resp_pend;
  logic [IW-1:0] r_id;

  logic w_grant;
  logic w_ts_start;
  logic w_ts_done;

  assign w_grant    = (r_state == HCI_TS_IDLE) & in_req_i & bank_gnt_i;
  assign w_ts_start = w_grant & in_wen_i & in_ts_set_i;
  assign w_ts_done  = (r_state == HCI_TS_WR) & bank_gnt_i;

  // Response path: registered valid/ID, read data straight from the bank.
  assign in_r_valid_o = r_resp_pend;
  assign in_r_id_o    = r_id;
  assign in_r_data_o  = bank_r_data_i;

  // Next-state and bank/grant muxing: pass-through in IDLE, locked write in TS_WR.
  always_comb begin
    w_state_next = r_state;
    bank_req_o   = in_req_i;
    bank_add_o   = in_add_i;
    bank_wen_o   = in_wen_i;
    bank_data_o  = in_data_i;
    bank_be_o    = in_be_i;
    in_gnt_o     = bank_gnt_i;
    case (r_state)
      HCI_TS_IDLE: begin
        if (w_ts_start) w_state_next = HCI_TS_WR;
      end
      HCI_TS_WR: begin
        bank_req_o  = 1'b1;
        bank_add_o  = r_ts_add;
        bank_wen_o  = 1'b0;
        bank_data_o = TS_WDATA;
        bank_be_o   = TS_WBE;
        in_gnt_o    = 1'b0;
        if (bank_gnt_i) w_state_next = HCI_TS_IDLE;
      end
    endcase
  end

`ifdef HCI_TS_ADAPTER_CNT_EN
  logic [31:0] r_ts_count;
  assign ts_count_o = r_ts_count;
`endif

  // State, response register, latched TS address and optional TS counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= HCI_TS_IDLE;
      r_ts_add    <= '0;
      r_resp_pend <= 1'b0;
      r_id        <= '0;
`ifdef HCI_TS_ADAPTER_CNT_EN
      r_ts_count  <= '0;
`endif
    end else begin
      r_state     <= w_state_next;
      r_resp_pend <= w_grant;
      if (w_grant)    r_id     <= in_id_i;
      if (w_ts_start) r_ts_add <= in_add_i;
`ifdef HCI_TS_ADAPTER_CNT_EN
      if (w_ts_done)  r_ts_count <= r_ts_count + 32'd1;
`endif
    end
  end

`ifndef HCI_TS_ADAPTER_CNT_EN
  logic w_unused;
  assign w_unused = w_ts_done;
`endif

endmodule

// File: tb/tb_hci_mem_ts_adapter.sv
// Self-checking bench for hci_mem_ts_adapter: directed scenarios followed by
// randomized traffic, compared against a word-level memory/response model.
module tb_hci_mem_ts_adapter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req = 1'b0;
  logic [9:0]  add = '0;
  logic        wen = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  be = '0;
  logic [7:0]  id = '0;
  logic        ts = 1'b0;
  logic        in_gnt_o, in_r_valid_o;
  logic [31:0] in_r_data_o;
  logic [7:0]  in_r_id_o;
  logic        bank_req_o, bank_wen_o;
  logic [9:0]  bank_add_o;
  logic [31:0] bank_data_o;
  logic [3:0]  bank_be_o;
  logic        bank_gnt = 1'b0;
  logic [31:0] bank_rdata;
`ifdef HCI_TS_ADAPTER_CNT_EN
  logic [31:0] ts_count_o;
`endif

  hci_mem_ts_adapter #(.AW(10), .DW(32), .BW(8), .IW(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
`ifdef HCI_TS_ADAPTER_CNT_EN
    .ts_count_o(ts_count_o),
`endif
    .in_req_i(req), .in_add_i(add), .in_wen_i(wen), .in_data_i(wdata),
    .in_be_i(be), .in_id_i(id), .in_ts_set_i(ts),
    .in_gnt_o(in_gnt_o), .in_r_valid_o(in_r_valid_o),
    .in_r_data_o(in_r_data_o), .in_r_id_o(in_r_id_o),
    .bank_req_o(bank_req_o), .bank_add_o(bank_add_o), .bank_wen_o(bank_wen_o),
    .bank_data_o(bank_data_o), .bank_be_o(bank_be_o),
    .bank_gnt_i(bank_gnt), .bank_r_data_i(bank_rdata)
  );

  always #5 clk = ~clk;

  // SRAM bank: read data valid the cycle after a granted read.
  bit [31:0] sram [1024];
  always @(posedge clk) begin
    if (bank_req_o && bank_gnt) begin
      if (bank_wen_o) bank_rdata <= sram[bank_add_o];
      else begin
        for (int unsigned b = 0; b < 4; b++)
          if (bank_be_o[b]) sram[bank_add_o][8*b +: 8] <= bank_data_o[8*b +: 8];
      end
    end
  end

  // Reference model: expected memory contents plus adapter-visible state.
  bit [31:0]   ref_mem [1024];
  bit          m_busy = 1'b0;
  logic [9:0]  m_tsadd = '0;
  bit          m_rv = 1'b0;
  bit          m_rd = 1'b0;
  logic [7:0]  m_rid = '0;
  logic [31:0] m_rdata = '0;
  logic [31:0] m_cnt = '0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] ben);
    logic [31:0] r;
    r = old;
    for (int unsigned b = 0; b < 4; b++)
      if (ben[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0;
    m_rv   = 1'b0;
    m_cnt  = '0;
  endfunction

  // One clock cycle with the current request inputs; called at posedge+1.
  task automatic step(input logic g, output bit granted);
    logic exp_gnt;
    bank_gnt = g;
    @(negedge clk);
    exp_gnt = !m_busy && g;
    chk("in_gnt", 32'(in_gnt_o), 32'(exp_gnt));
    chk("r_valid", 32'(in_r_valid_o), 32'(m_rv));
    if (m_rv) begin
      chk("r_id", 32'(in_r_id_o), 32'(m_rid));
      if (m_rd) chk("r_data", in_r_data_o, m_rdata);
    end
    if (m_busy) begin
      chk("ts_bank_req", 32'(bank_req_o), 32'd1);
      chk("ts_bank_wen", 32'(bank_wen_o), 32'd0);
      chk("ts_bank_add", 32'(bank_add_o), 32'(m_tsadd));
      chk("ts_bank_data", bank_data_o, 32'hFFFF_FFFF);
      chk("ts_bank_be", 32'(bank_be_o), 32'hF);
    end else begin
      chk("pt_bank_req", 32'(bank_req_o), 32'(req));
      chk("pt_bank_add", 32'(bank_add_o), 32'(add));
      chk("pt_bank_wen", 32'(bank_wen_o), 32'(wen));
      chk("pt_bank_data", bank_data_o, wdata);
      chk("pt_bank_be", 32'(bank_be_o), 32'(be));
    end
`ifdef HCI_TS_ADAPTER_CNT_EN
    chk("ts_count", ts_count_o, m_cnt);
`endif
    @(posedge clk);
    granted = exp_gnt && req;
    if (m_busy && g) begin
      ref_mem[m_tsadd] = 32'hFFFF_FFFF;
      m_busy = 1'b0;
      m_cnt  = m_cnt + 32'd1;
    end
    m_rv = granted;
    if (granted) begin
      m_rd  = wen;
      m_rid = id;
      if (wen) begin
        m_rdata = ref_mem[add];
        if (ts) begin
          m_busy  = 1'b1;
          m_tsadd = add;
        end
      end else begin
        ref_mem[add] = merge_be(ref_mem[add], wdata, be);
      end
    end
    #1;
  endtask

  task automatic set_req(input logic r, input logic w, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] b,
                         input logic [7:0] i, input logic t);
    req = r; wen = w; add = a; wdata = d; be = b; id = i; ts = t;
  endtask

  initial begin
    bit gr;
    bit pend;
    // Reset state
    #12;
    chk("rst_r_valid", 32'(in_r_valid_o), 32'd0);
    chk("rst_r_id", 32'(in_r_id_o), 32'd0);
    chk("rst_bank_req", 32'(bank_req_o), 32'(req));
`ifdef HCI_TS_ADAPTER_CNT_EN
    chk("rst_ts_count", ts_count_o, 32'd0);
`endif
    model_reset();
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // Write then read
    set_req(1, 0, 10'd5, 32'hDEAD_BEEF, 4'hF, 8'd3, 0); step(1, gr);
    set_req(1, 1, 10'd5, 32'h0, 4'hF, 8'd4, 0);          step(1, gr);
    set_req(0, 1, 10'd0, 32'h0, 4'h0, 8'd0, 0);          step(1, gr);

    // Test-and-set on zero, with a read of the same word waiting behind it
    set_req(1, 1, 10'd7, 32'h0, 4'hF, 8'd6, 1); step(1, gr);
    set_req(1, 1, 10'd7, 32'h0, 4'hF, 8'd9, 0); step(1, gr);
    step(1, gr);
    set_req(0, 1, 10'd0, 32'h0, 4'h0, 8'd0, 0); step(1, gr);
    step(1, gr);

    // Stalled TS write
    set_req(1, 0, 10'd9, 32'hA5A5_1234, 4'hF, 8'd1, 0); step(1, gr);
    set_req(1, 1, 10'd9, 32'h0, 4'hF, 8'd2, 1);          step(1, gr);
    set_req(1, 1, 10'd9, 32'h0, 4'hF, 8'd3, 0);
    step(0, gr); step(0, gr); step(0, gr); step(1, gr);
    step(1, gr);
    set_req(0, 1, 10'd0, 32'h0, 4'h0, 8'd0, 0); step(1, gr);

    // Back-to-back test-and-sets to the same word
    set_req(1, 0, 10'd11, 32'h0BAD_F00D, 4'hF, 8'd10, 0); step(1, gr);
    set_req(1, 1, 10'd11, 32'h0, 4'hF, 8'd11, 1);          step(1, gr);
    set_req(1, 1, 10'd11, 32'h0, 4'hF, 8'd12, 1);          step(1, gr);
    step(1, gr);
    set_req(0, 1, 10'd0, 32'h0, 4'h0, 8'd0, 0); step(1, gr);
    step(1, gr);

    // Reset during TS_WR drops the write and the response
    set_req(1, 0, 10'd13, 32'h1357_9BDF, 4'hF, 8'd20, 0); step(1, gr);
    set_req(1, 1, 10'd13, 32'h0, 4'hF, 8'd21, 1);          step(1, gr);
    set_req(0, 1, 10'd0, 32'h0, 4'h0, 8'd0, 0);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_r_valid", 32'(in_r_valid_o), 32'd0);
    chk("mid_rst_bank_req", 32'(bank_req_o), 32'd0);
    chk("mid_rst_gnt", 32'(in_gnt_o), 32'(bank_gnt));
    model_reset();
    @(posedge clk); #1;
    rst_ni = 1'b1;
    set_req(1, 1, 10'd13, 32'h0, 4'hF, 8'd22, 0); step(1, gr);
    set_req(0, 1, 10'd0, 32'h0, 4'h0, 8'd0, 0);  step(1, gr);

    // TS flag on a write is an ordinary write; next request granted at once
    set_req(1, 0, 10'd20, 32'h1234_5678, 4'hF, 8'd30, 1); step(1, gr);
    set_req(1, 1, 10'd20, 32'h0, 4'hF, 8'd31, 0);          step(1, gr);
    set_req(0, 1, 10'd0, 32'h0, 4'h0, 8'd0, 0);           step(1, gr);

    // Partial byte-enable write
    set_req(1, 0, 10'd20, 32'hAABB_CCDD, 4'b0101, 8'd32, 0); step(1, gr);
    set_req(1, 1, 10'd20, 32'h0, 4'hF, 8'd33, 0);             step(1, gr);
    set_req(0, 1, 10'd0, 32'h0, 4'h0, 8'd0, 0);              step(1, gr);

    // Random traffic; an ungranted request stays stable until granted
    pend = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!pend) begin
        if ($urandom_range(0, 3) != 0)
          set_req(1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), 8'($urandom), 1'($urandom_range(0, 3) == 0));
        else
          set_req(0, 1, 10'($urandom_range(0, 15)), $urandom, 4'h0, 8'd0, 0);
      end
      step($urandom_range(0, 3) != 0, gr);
      pend = req && !gr;
    end
    set_req(0, 1, 10'd0, 32'h0, 4'h0, 8'd0, 0);
    step(1, gr); step(1, gr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
